// File: rtl/sequenciador_decodificador_if.sv
// Code-queue, decoder-drive and run-status signals between the sequencer and its environment.
interface sequenciador_decodificador_if;
    logic [6:0] Codigo;
    logic       CodigoValido;
    logic       Pronto;
    logic       Inicio;
    logic [3:0] EstadoDec;
    logic [6:0] EntradaDec;
    logic       Controle;
    logic       ResetDec;
    logic       Ocupado;
    logic [1:0] Resultado;
    logic       ResultadoValido;
    logic [3:0] Contagem;

    modport master (
        output Codigo, CodigoValido, Inicio, EstadoDec,
        input  Pronto, EntradaDec, Controle, ResetDec, Ocupado,
        input  Resultado, ResultadoValido, Contagem
    );

    modport slave (
        input  Codigo, CodigoValido, Inicio, EstadoDec,
        output Pronto, EntradaDec, Controle, ResetDec, Ocupado,
        output Resultado, ResultadoValido, Contagem
    );
endinterface

// File: rtl/sequenciador_decodificador.sv
// Feeds queued 7-bit codes to a decoder FSM one step at a time; 5 cycles Inicio->result, +3 per extra step.
// Pronto drops while the 4-deep queue is full and during FIM.
module sequenciador_decodificador #(
    parameter int MAX_PASSOS = 12
) (
    input logic                         clk,
    input logic                         Reset,
    sequenciador_decodificador_if.slave bus
);
    typedef enum logic [2:0] {OCIOSO, LIMPA, ESPERA, ENVIA, AVALIA, FIM} estado_t;

    localparam logic [3:0] MAX_P = 4'(MAX_PASSOS);

    estado_t    state_q, state_d;
    logic [6:0] mem_q [4];
    logic [6:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic [6:0] entrada_q, entrada_d;
    logic       controle_q, controle_d;
    logic       reset_dec_q, reset_dec_d;
    logic       res_vld_q, res_vld_d;
    logic [1:0] resultado_q, resultado_d;
    logic [3:0] contagem_q, contagem_d;
    logic       pronto, wr_en, rd_en;

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        entrada_d   = entrada_q;
        resultado_d = resultado_q;
        contagem_d  = contagem_q;
        pronto      = (count_q != 3'd4) && (state_q != FIM);
        wr_en       = bus.CodigoValido && pronto;
        rd_en       = (state_q == ESPERA) && (count_q != 3'd0);

        case (state_q)
            OCIOSO: if (bus.Inicio) state_d = LIMPA;
            LIMPA:  state_d = ESPERA;
            ESPERA: if (rd_en) state_d = ENVIA;
            ENVIA:  state_d = AVALIA;
            AVALIA: begin
                // Decoder verdicts take priority over the step limit on the last step.
                if (bus.EstadoDec == 4'd8) begin
                    resultado_d = 2'b11;
                    state_d     = FIM;
                end else if (bus.EstadoDec == 4'd9) begin
                    resultado_d = 2'b01;
                    state_d     = FIM;
                end else if (bus.EstadoDec == 4'd10) begin
                    resultado_d = 2'b10;
                    state_d     = FIM;
                end else if (contagem_q == MAX_P) begin
                    resultado_d = 2'b00;
                    state_d     = FIM;
                end else begin
                    state_d = ESPERA;
                end
            end
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase

        if (wr_en) begin
            mem_d[wr_ptr_q] = bus.Codigo;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (rd_en) begin
            entrada_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, wr_en} - {2'b00, rd_en};
        if (state_q == FIM) begin
            count_d  = 3'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end

        if (state_d == LIMPA) begin
            contagem_d  = 4'd0;
            resultado_d = 2'b00;
        end
        if (state_d == ENVIA && contagem_q != 4'd15) contagem_d = contagem_q + 4'd1;

        // Strobes are registered from the next state so they line up with it exactly.
        controle_d  = (state_d == ENVIA);
        reset_dec_d = (state_d == LIMPA);
        res_vld_d   = (state_d == FIM);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= OCIOSO;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            entrada_q   <= 7'd0;
            controle_q  <= 1'b0;
            reset_dec_q <= 1'b0;
            res_vld_q   <= 1'b0;
            resultado_q <= 2'b00;
            contagem_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            entrada_q   <= entrada_d;
            controle_q  <= controle_d;
            reset_dec_q <= reset_dec_d;
            res_vld_q   <= res_vld_d;
            resultado_q <= resultado_d;
            contagem_q  <= contagem_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.Pronto          = pronto;
    assign bus.EntradaDec      = entrada_q;
    assign bus.Controle        = controle_q;
    assign bus.ResetDec        = reset_dec_q;
    assign bus.Ocupado         = (state_q != OCIOSO);
    assign bus.Resultado       = resultado_q;
    assign bus.ResultadoValido = res_vld_q;
    assign bus.Contagem        = contagem_q;
endmodule

// File: tb/tb_sequenciador_decodificador.sv
// Directed and randomized runs of the code sequencer against a scripted decoder and a step/result model.
module tb_sequenciador_decodificador;
    localparam int MAX = 12;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    sequenciador_decodificador_if bus ();

    sequenciador_decodificador #(.MAX_PASSOS(MAX)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Scripted decoder: each applied code moves it to the next scripted state.
    logic [3:0] script [16];
    logic [3:0] dec_st;
    logic [3:0] dec_idx;
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            dec_st  <= 4'd0;
            dec_idx <= 4'd0;
        end else if (bus.ResetDec) begin
            dec_st  <= 4'd0;
            dec_idx <= 4'd0;
        end else if (bus.Controle) begin
            dec_st  <= script[dec_idx];
            dec_idx <= dec_idx + 4'd1;
        end
    end
    assign bus.EstadoDec = dec_st;

    logic [6:0] pend [$];
    logic [6:0] sent [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_steps();
        for (int i = 0; i < MAX; i++)
            if (script[i] == 4'd8 || script[i] == 4'd9 || script[i] == 4'd10) return i + 1;
        return MAX;
    endfunction

    function automatic logic [1:0] model_res();
        int k;
        k = model_steps();
        case (script[k-1])
            4'd8:    return 2'b11;
            4'd9:    return 2'b01;
            4'd10:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive_feed();
        if (pend.size() > 0) begin
            bus.CodigoValido = 1'b1;
            bus.Codigo       = pend[0];
            if (bus.Pronto) sent.push_back(pend.pop_front());
        end else begin
            bus.CodigoValido = 1'b0;
        end
    endtask

    task automatic prequeue(input int n);
        for (int i = 0; i < n; i++) begin
            drive_feed();
            cycle_edge();
        end
        bus.CodigoValido = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_controle"}, bus.Controle, 0);
        chk({tag, "_resetdec"}, bus.ResetDec, 0);
        chk({tag, "_entrada"}, bus.EntradaDec, 0);
        chk({tag, "_ocupado"}, bus.Ocupado, 0);
        chk({tag, "_resultado"}, bus.Resultado, 0);
        chk({tag, "_vld"}, bus.ResultadoValido, 0);
        chk({tag, "_contagem"}, bus.Contagem, 0);
        chk({tag, "_pronto"}, bus.Pronto, 1);
    endtask

    task automatic run_case(input string tag, input int n_pre, input bit pronto_chk);
        int k, lat, ctl, both;
        logic [1:0] r;
        bit done;
        k = model_steps();
        r = model_res();
        lat = 0; ctl = 0; both = 0; done = 0;
        prequeue(n_pre);
        bus.Inicio = 1'b1;
        drive_feed();
        cycle_edge();
        bus.Inicio = 1'b0;
        lat = 1;
        chk({tag, "_limpa_resetdec"}, bus.ResetDec, 1);
        chk({tag, "_limpa_contagem"}, bus.Contagem, 0);
        chk({tag, "_limpa_ocupado"}, bus.Ocupado, 1);
        if (pronto_chk) chk({tag, "_pronto_full"}, bus.Pronto, 0);
        for (int c = 0; c < 200 && !done; c++) begin
            if (bus.Controle) begin
                chk({tag, "_entrada"}, bus.EntradaDec,
                    (ctl < sent.size()) ? 32'(sent[ctl]) : 32'hFFFF_FFFF);
                if (pronto_chk && ctl == 0) chk({tag, "_pronto_after_pop"}, bus.Pronto, 1);
                if (bus.ResetDec) both++;
                ctl++;
            end
            if (bus.ResultadoValido) done = 1;
            else begin
                drive_feed();
                cycle_edge();
                lat++;
            end
        end
        bus.CodigoValido = 1'b0;
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_resultado"}, bus.Resultado, r);
        chk({tag, "_contagem"}, bus.Contagem, k);
        chk({tag, "_latency"}, lat, 3 * k + 2);
        chk({tag, "_steps"}, ctl, k);
        chk({tag, "_ctl_rst_overlap"}, both, 0);
        cycle_edge();
        chk({tag, "_vld_pulse"}, bus.ResultadoValido, 0);
        chk({tag, "_idle_ocupado"}, bus.Ocupado, 0);
        chk({tag, "_hold_resultado"}, bus.Resultado, r);
        chk({tag, "_hold_contagem"}, bus.Contagem, k);
        chk({tag, "_flushed_pronto"}, bus.Pronto, 1);
    endtask

    task automatic fill_script(input logic [3:0] v);
        for (int i = 0; i < 16; i++) script[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int ctl, vld, rate, v, m, np;
        bus.Codigo = 7'd0;
        bus.CodigoValido = 1'b0;
        bus.Inicio = 1'b0;
        fill_script(4'd3);
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1 check_reset("rst");
        repeat (2) cycle_edge();
        Reset = 1'b1;
        cycle_edge();
        check_reset("post_rst");

        // Accept in state 9
        pend.delete(); sent.delete();
        pend.push_back(7'b1100000); pend.push_back(7'b1001001);
        fill_script(4'd3); script[0] = 4'd1; script[1] = 4'd9;
        run_case("acc9", 2, 0);

        // Accept in state 10
        pend.delete(); sent.delete();
        pend.push_back(7'b1011010); pend.push_back(7'b1010011);
        fill_script(4'd3); script[0] = 4'd4; script[1] = 4'd10;
        run_case("acc10", 2, 0);

        // Error state with a third code left queued and flushed
        pend.delete(); sent.delete();
        pend.push_back(7'b1100000); pend.push_back(7'b1111100); pend.push_back(7'b1000100);
        fill_script(4'd3); script[0] = 4'd1; script[1] = 4'd8;
        run_case("err8", 3, 0);

        // Timeout after MAX steps
        pend.delete(); sent.delete();
        for (int i = 0; i < MAX; i++) begin
            pend.push_back((i % 2 == 0) ? 7'b1100000 : 7'b1000100);
            script[i] = (i % 2 == 0) ? 4'd1 : 4'd4;
        end
        run_case("timeout", 4, 0);

        // Five back-to-back writes into an idle, empty queue
        pend.delete(); sent.delete();
        for (int i = 0; i < 5; i++) begin
            bus.CodigoValido = 1'b1;
            bus.Codigo = 7'(7'h11 * (i + 1));
            chk($sformatf("full_pronto_w%0d", i), bus.Pronto, (i < 4) ? 1 : 0);
            if (bus.Pronto) sent.push_back(bus.Codigo);
            cycle_edge();
        end
        bus.CodigoValido = 1'b0;
        fill_script(4'd3); script[0] = 4'd1; script[1] = 4'd2; script[2] = 4'd5; script[3] = 4'd9;
        run_case("full", 0, 1);

        // Reset during AVALIA of step 2
        pend.delete(); sent.delete();
        for (int i = 0; i < 16; i++) script[i] = 4'(1 + (i % 5));
        pend.push_back(7'h0A); pend.push_back(7'h0B); pend.push_back(7'h0C);
        prequeue(3);
        bus.Inicio = 1'b1;
        cycle_edge();
        bus.Inicio = 1'b0;
        ctl = 0; vld = 0;
        for (int c = 0; c < 40 && ctl < 2; c++) begin
            cycle_edge();
            if (bus.Controle) ctl++;
            if (bus.ResultadoValido) vld++;
        end
        chk("mid_two_steps", ctl, 2);
        cycle_edge();
        chk("mid_avalia_ocupado", bus.Ocupado, 1);
        Reset = 1'b0;
        #1 check_reset("mid");
        repeat (3) begin
            cycle_edge();
            if (bus.ResultadoValido) vld++;
        end
        Reset = 1'b1;
        cycle_edge();
        if (bus.ResultadoValido) vld++;
        chk("mid_no_vld", vld, 0);
        check_reset("mid_released");
        pend.delete(); sent.delete();
        pend.push_back(7'h21); pend.push_back(7'h22);
        fill_script(4'd3); script[0] = 4'd6; script[1] = 4'd9;
        run_case("mid_rerun", 2, 0);

        // Randomized runs
        for (int n = 0; n < 20; n++) begin
            rate = ($urandom_range(0, 1) == 1) ? 30 : 5;
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 99) < rate) script[i] = 4'(8 + $urandom_range(0, 2));
                else begin
                    v = $urandom_range(0, 12);
                    script[i] = 4'((v >= 8) ? v + 3 : v);
                end
            end
            pend.delete(); sent.delete();
            m = model_steps() + $urandom_range(0, 3);
            for (int i = 0; i < m; i++) pend.push_back(7'($urandom_range(0, 127)));
            np = $urandom_range(1, 4);
            if (np > pend.size()) np = pend.size();
            run_case($sformatf("rnd%0d", n), np, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sequenciador_decodificador.md
SEQUENCIADOR_DECODIFICADOR -- requirements
Module: sequenciador_decodificador

Interface
REQ-001 SHALL have parameter MAX_PASSOS, default 12: maximum number of codes applied per run before timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port Codigo, input, 7: 7-bit code offered for queuing.
REQ-005 SHALL have port CodigoValido, input, 1: Codigo is valid this cycle.
REQ-006 SHALL have port Pronto, output, 1: queue can accept a code; a write occurs when CodigoValido and Pronto are both high.
REQ-007 SHALL have port Inicio, input, 1: start-run request.
REQ-008 SHALL have port EstadoDec, input, 4: current state from the 7-bit-code decoder FSM.
REQ-009 SHALL have port EntradaDec, output, 7: code driven to the decoder.
REQ-010 SHALL have port Controle, output, 1: decoder step enable.
REQ-011 SHALL have port ResetDec, output, 1: synchronous active-high clear to the decoder.
REQ-012 SHALL have port Ocupado, output, 1: a run is in progress.
REQ-013 SHALL have port Resultado, output, 2: run result; 01 = accept state 9, 10 = accept state 10, 11 = error state 8, 00 = timeout.
REQ-014 SHALL have port ResultadoValido, output, 1: one-cycle pulse marking Resultado valid.
REQ-015 SHALL have port Contagem, output, 4: number of codes applied in the current or last run.

Function
REQ-016 SHALL contain a 4-entry FIFO of 7-bit codes; Pronto = not full and state != FIM; writes are accepted in any other state, including OCIOSO.
REQ-017 SHALL implement the FSM OCIOSO -> LIMPA -> ESPERA -> ENVIA -> AVALIA -> (ESPERA | FIM) -> OCIOSO.
REQ-018 OCIOSO: Ocupado=0; Inicio=1 -> LIMPA. Inicio in any other state SHALL be ignored.
REQ-019 LIMPA (exactly 1 cycle): ResetDec=1, Contagem cleared to 0, Ocupado=1; next state ESPERA.
REQ-020 ESPERA: if FIFO non-empty, pop head into EntradaDec and go to ENVIA; else remain. There is no idle timeout.
REQ-021 ENVIA (exactly 1 cycle): Controle=1, EntradaDec stable, Contagem incremented; next state AVALIA.
REQ-022 AVALIA (1 cycle): sample EstadoDec (decoder updated at the ENVIA edge).
 - 8 -> Resultado=11, FIM.
 - 9 -> Resultado=01, FIM.
 - 10 -> Resultado=10, FIM.
 - else, if Contagem == MAX_PASSOS -> Resultado=00, FIM.
 - else -> ESPERA.
REQ-023 FIM (1 cycle): ResultadoValido=1 and all FIFO contents are flushed; next state OCIOSO.
REQ-024 Resultado and Contagem SHALL hold their values until the next LIMPA.
REQ-025 Controle, ResetDec, EntradaDec, ResultadoValido and Pronto SHALL be registered outputs, except Pronto, which may be combinational from registered state.
REQ-026 Controle and ResetDec SHALL never be high in the same cycle; Controle SHALL be high only in ENVIA.
REQ-027 Codes the decoder does not recognise count as a step (Contagem increments) and leave the run in progress.
REQ-028 A write and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-029 Contagem SHALL saturate at 15.
REQ-030 MAX_PASSOS SHALL be in the range 1..15.
REQ-031 Minimum run latency, Inicio to ResultadoValido with a code already queued, SHALL be 5 cycles.

Reset
REQ-032 Reset low SHALL immediately force:
 - state OCIOSO;
 - FIFO empty;
 - Controle=0, ResetDec=0, EntradaDec=0, Ocupado=0, Resultado=00, ResultadoValido=0, Contagem=0.
REQ-033 Reset asserted mid-run SHALL abort the run with no ResultadoValido pulse; the next run's LIMPA re-clears the decoder.
REQ-034 Outputs SHALL be defined from the first edge after Reset deasserts.

Verification
REQ-035 Queue 1100000, 1001001, then Inicio -> two Controle pulses; EstadoDec goes 1 then 9; Resultado=01, Contagem=2, one ResultadoValido pulse.
REQ-036 Queue 1011010, 1010011 -> EstadoDec 4 then 10; Resultado=10, Contagem=2.
REQ-037 Queue 1100000, 1111100, 1000100 -> EstadoDec 1 then 8; Resultado=11, Contagem=2; the third code is flushed in FIM and never applied.
REQ-038 Alternate 1100000/1000100, 12 codes, MAX_PASSOS=12 -> Resultado=00, Contagem=12.
REQ-039 Write 5 codes back-to-back in OCIOSO -> Pronto falls after the 4th write, the 5th is not stored, and Pronto returns high after the first pop.
REQ-040 Assert Reset during AVALIA of step 2 -> all outputs return to their reset values immediately and no ResultadoValido pulse occurs; a new run then starts with ResetDec high in LIMPA.
